// File: rtl/serial_word_sender.sv
// Parallel-to-serial word sender: accepts a word via valid/ready and drives it
// bit-serially on D, each bit held HOLD_CYCLES clocks, then an optional zero gap.
module serial_word_sender #(
   parameter int WIDTH       = 4,
   parameter int HOLD_CYCLES = 2,
   parameter int GAP_CYCLES  = 1,
   parameter int MSB_FIRST   = 1
) (
   input  logic             clock,
   input  logic             reset_b,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             D,
   output logic             busy,
   output logic             done
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int BIT_W  = $clog2(WIDTH);
   localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  sreg_q, sreg_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              d_q, d_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic last_hold;
   logic last_bit;
   logic accept;

   assign last_hold = (hold_q == HOLD_LAST);
   assign last_bit  = (bit_q == BIT_LAST);
   assign in_ready  = reset_b &&
                      ((state_q == ST_IDLE) ||
                       ((GAP_CYCLES == 0) && (state_q == ST_SHIFT) && last_hold && last_bit));
   assign accept    = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      hold_d  = hold_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      d_d     = d_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            d_d    = 1'b0;
            busy_d = 1'b0;
         end
         ST_SHIFT: begin
            if (!last_hold) begin
               hold_d = hold_q + 1'b1;
            end else begin
               hold_d = '0;
               if (!last_bit) begin
                  bit_d = bit_q + 1'b1;
                  if (MSB_FIRST != 0) begin
                     sreg_d = sreg_q << 1;
                     d_d    = sreg_q[WIDTH-2];
                  end else begin
                     sreg_d = sreg_q >> 1;
                     d_d    = sreg_q[1];
                  end
               end else begin
                  done_d = 1'b1;
                  bit_d  = '0;
                  d_d    = 1'b0;
                  busy_d = 1'b0;
                  gap_d  = '0;
                  state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            d_d    = 1'b0;
            busy_d = 1'b0;
            if (gap_q == GAP_LAST) state_d = ST_IDLE;
            else                   gap_d   = gap_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // A load overrides the word-end path above so gapless words keep done pulsing.
      if (accept) begin
         state_d = ST_SHIFT;
         sreg_d  = in_data;
         hold_d  = '0;
         bit_d   = '0;
         busy_d  = 1'b1;
         d_d     = (MSB_FIRST != 0) ? in_data[WIDTH-1] : in_data[0];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_b) begin
         state_q <= ST_IDLE;
         sreg_q  <= '0;
         hold_q  <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         d_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         hold_q  <= hold_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         d_q     <= d_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign D    = d_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
